// File: rtl/panel_mem_pkg.sv
// rtl/panel_mem_pkg.sv - shared constants, state encoding and address wrap for the panel memory reader
package panel_mem_pkg;

    localparam int ADDR_W         = 7;
    localparam int NUM_WORDS      = 95;
    localparam int DATA_W         = 512;
    localparam int OUT_W          = 32;
    localparam int BEATS_PER_WORD = DATA_W / OUT_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    // Memory depth is not a power of two, so the word address wraps explicitly.
    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(NUM_WORDS - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/panel_word_serializer.sv
// rtl/panel_word_serializer.sv - loads one memory word and shifts it out as OUT_W-bit beats
// Ports: load/load_data capture a word; tdata/tvalid/tready carry beats, low bits first;
//        tlast marks the final beat of the word; first_beat marks beat 0; last_fire
//        pulses when the final beat is accepted.
module panel_word_serializer
    import panel_mem_pkg::*;
#(
    parameter int DATA_W = panel_mem_pkg::DATA_W,
    parameter int OUT_W  = panel_mem_pkg::OUT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic [OUT_W-1:0]  tdata,
    output logic              tvalid,
    input  logic              tready,
    output logic              tlast,
    output logic              first_beat,
    output logic              last_fire
);

    localparam int N_BEATS = DATA_W / OUT_W;
    localparam int CNT_W   = $clog2(N_BEATS);

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  beat;
    logic              valid_q;
    logic              fire;

    assign fire       = valid_q && tready;
    assign tdata      = shreg[OUT_W-1:0];
    assign tvalid     = valid_q;
    assign tlast      = (beat == CNT_W'(N_BEATS - 1));
    assign first_beat = (beat == '0);
    assign last_fire  = fire && tlast;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg   <= '0;
            beat    <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            shreg   <= load_data;
            beat    <= '0;
            valid_q <= 1'b1;
        end else if (fire) begin
            // Zeros shift in, so the output settles to 0 once a word is drained.
            shreg <= shreg >> OUT_W;
            beat  <= beat + CNT_W'(1);
            if (tlast) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/panel_mem_reader.sv
// rtl/panel_mem_reader.sv - Avalon-MM read master streaming memory words as 32-bit packets
// Ports: start/base_addr/word_count request a run; busy/done/error report progress;
//        avm_* is the memory read port (latency 1); st_* is the output packet stream.
module panel_mem_reader
    import panel_mem_pkg::*;
#(
    parameter int ADDR_W    = panel_mem_pkg::ADDR_W,
    parameter int NUM_WORDS = panel_mem_pkg::NUM_WORDS,
    parameter int DATA_W    = panel_mem_pkg::DATA_W,
    parameter int OUT_W     = panel_mem_pkg::OUT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_read,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [OUT_W-1:0]  st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop
);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] cnt_q;      // words still to deliver, including the current one
    logic              first_q;    // current word is the first of the packet
    logic              err_q;
    logic              bad_req;
    logic              load;
    logic              word_last;
    logic              first_beat;
    logic              last_fire;

    assign bad_req = (base_addr >= ADDR_W'(NUM_WORDS)) || (word_count > ADDR_W'(NUM_WORDS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q  <= base_addr;
                        cnt_q   <= word_count;
                        first_q <= 1'b1;
                        if (bad_req) begin
                            err_q   <= 1'b1;
                            state_q <= S_FIN;
                        end else if (word_count == '0) begin
                            state_q <= S_FIN;
                        end else begin
                            state_q <= S_READ;
                        end
                    end
                end
                S_READ:  state_q <= S_WAIT;
                S_WAIT:  state_q <= S_SHIFT;
                S_SHIFT: begin
                    if (last_fire) begin
                        first_q <= 1'b0;
                        cnt_q   <= cnt_q - ADDR_W'(1);
                        if (cnt_q == ADDR_W'(1)) begin
                            state_q <= S_FIN;
                        end else begin
                            addr_q  <= wrap_addr(addr_q);
                            state_q <= S_READ;
                        end
                    end
                end
                S_FIN: begin
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_FIN);
    assign error          = err_q;
    assign avm_read       = (state_q == S_READ);
    assign avm_chipselect = (state_q == S_READ);
    assign avm_address    = addr_q;
    // Read data arrives during WAIT; it is loaded at the end of that cycle.
    assign load           = (state_q == S_WAIT);

    panel_word_serializer #(
        .DATA_W(DATA_W),
        .OUT_W (OUT_W)
    ) u_ser (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .load_data (avm_readdata),
        .tdata     (st_data),
        .tvalid    (st_valid),
        .tready    (st_ready),
        .tlast     (word_last),
        .first_beat(first_beat),
        .last_fire (last_fire)
    );

    assign st_sop = st_valid && first_q && first_beat;
    assign st_eop = st_valid && word_last && (cnt_q == ADDR_W'(1));

endmodule
